rst_ctrl: RTL and testbench

RST_CTRL -- requirements
Module: rst_ctrl

---
 rtl/rst_ctrl_pkg.sv | 25 ++
 rtl/rst_sync_chain.sv | 37 +++
 rtl/rst_ctrl.sv | 111 +++++++++++
 tb/tb_rst_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_ctrl_pkg.sv
// rst_ctrl_pkg
// Shared definitions for the reset controller slice.
// Contents:
//   state_e                - controller states (SYNC, HOLD, RUN)
//   DEFAULT_SYNC_STAGES    - default synchronizer depth on reset release
//   DEFAULT_HOLD_CYCLES    - default reset stretch length in clk cycles
//   cnt_width()            - width of the stretch counter for a given hold length
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_HOLD_CYCLES = 16;

  // The counter only ever needs to reach hold-1, so clog2(hold) bits suffice;
  // a hold of 1 would give zero bits, so keep at least one.
  function automatic int cnt_width(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain
// Reset-release synchronizer: a chain of STAGES flops whose input is tied
// to 1. All stages clear asynchronously on rst and a 1 walks in one stage
// per clock edge after rst is released.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears every stage
//   q    - last stage of the chain (1 once release has propagated through)
module rst_sync_chain
  import rst_ctrl_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift a constant 1 in at the bottom of the chain.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/rst_ctrl.sv
// rst_ctrl
// Reset controller: synchronizes release of the external reset, stretches
// the downstream reset for HOLD_CYCLES clocks, and accepts software reset
// requests once running.
// Ports:
//   clk         - single rising-edge clock
//   rst         - asynchronous active-high reset (the only reset of this block)
//   sw_rst_req  - synchronous active-high software reset request
//   rst_n_out   - downstream active-low reset, async assert / sync deassert
//   rst_out     - downstream active-high reset, always ~rst_n_out
//   rst_done    - one-cycle pulse after the reset release completes
//   busy        - high whenever the controller is not in RUN
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_rst_req,
  output logic rst_n_out,
  output logic rst_out,
  output logic rst_done,
  output logic busy
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  logic sync_done;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rst_n_q, rst_n_d;
  logic          done_q, done_d;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .q   (sync_done)
  );

  // Next-state logic. rst_n_d is decided alongside the state so that the
  // output flop rises on exactly the HOLD->RUN edge and falls on the edge
  // a software request is accepted; it is never decoded from state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = 1'b0;
    case (state_q)
      ST_SYNC: begin
        rst_n_d = 1'b0;
        cnt_d   = '0;
        if (sync_done) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        rst_n_d = 1'b0;
        // A fresh request restarts the stretch, even on the final count.
        if (sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          rst_n_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        rst_n_d = 1'b1;
        cnt_d   = '0;
        if (sw_rst_req) begin
          state_d = ST_HOLD;
          rst_n_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
        rst_n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign rst_out   = ~rst_n_q;
  assign rst_done  = done_q;
  assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_rst_ctrl.sv
// tb_rst_ctrl
// Self-checking bench for rst_ctrl. Two instances share stimulus: the
// default configuration (2 sync stages, 16 hold cycles) and a swept one
// (3 sync stages, 1 hold cycle). Expected outputs come from a timestamp
// model: each instance tracks edges since reset release, the edge where the
// current stretch began, and whether it is running.
module tb_rst_ctrl;

  logic clk;
  logic rst;
  logic sw_rst_req;

  logic a_rst_n, a_rst_out, a_done, a_busy;
  logic b_rst_n, b_rst_out, b_done, b_busy;

  int n_checks;
  int n_fails;

  // Model configuration and state, index 0 = default instance, 1 = swept.
  int NS [2];
  int HS [2];
  int k [2];
  bit running [2];
  int hold_start [2];
  bit done_now [2];

  rst_ctrl dut_a (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (a_rst_n),
    .rst_out    (a_rst_out),
    .rst_done   (a_done),
    .busy       (a_busy)
  );

  rst_ctrl #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (b_rst_n),
    .rst_out    (b_rst_out),
    .rst_done   (b_done),
    .busy       (b_busy)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i]          = 0;
      running[i]    = 1'b0;
      hold_start[i] = -1000;
      done_now[i]   = 1'b0;
    end
  endtask

  // Advance one instance's model by one clock edge with request value req.
  // Release happens H edges after the stretch start; a stretch starts on the
  // edge after the synchronizer fills (edge N+1) or on any later accepted
  // request, and a request on the would-be release edge wins.
  task automatic model_edge(input int i, input logic req);
    if (rst) begin
      k[i]          = 0;
      running[i]    = 1'b0;
      hold_start[i] = -1000;
      done_now[i]   = 1'b0;
      return;
    end
    k[i]++;
    done_now[i] = 1'b0;
    if (running[i]) begin
      if (req) begin
        running[i]    = 1'b0;
        hold_start[i] = k[i];
      end
    end else if (k[i] == NS[i] + 1) begin
      hold_start[i] = k[i];
    end else if (k[i] > NS[i] + 1) begin
      if (req) begin
        hold_start[i] = k[i];
      end else if (k[i] == hold_start[i] + HS[i]) begin
        running[i]  = 1'b1;
        done_now[i] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, "/a_rst_n"},   a_rst_n,   running[0]);
    check1({tag, "/a_rst_out"}, a_rst_out, ~running[0]);
    check1({tag, "/a_done"},    a_done,    done_now[0]);
    check1({tag, "/a_busy"},    a_busy,    ~running[0]);
    check1({tag, "/b_rst_n"},   b_rst_n,   running[1]);
    check1({tag, "/b_rst_out"}, b_rst_out, ~running[1]);
    check1({tag, "/b_done"},    b_done,    done_now[1]);
    check1({tag, "/b_busy"},    b_busy,    ~running[1]);
  endtask

  // Drive req, take one rising edge, advance the model, then sample 1 unit later.
  task automatic applyStimulus(input logic req);
    sw_rst_req = req;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, req);
    #1;
    checkOutput("edge");
  endtask

  // Assert rst between edges, check the asynchronous response, keep it for
  // hold_edges clock edges, then release it mid-cycle.
  task automatic asyncResetPulse(input int hold_edges);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("async_assert");
    check1("async_a_rst_n", a_rst_n, 1'b0);
    check1("async_b_rst_n", b_rst_n, 1'b0);
    repeat (hold_edges) applyStimulus(1'b0);
    #3;
    rst = 1'b0;
  endtask

  // Count edges until the default instance releases, bounded by limit.
  task automatic waitRise(input int limit, output int edges);
    edges = 0;
    while (a_rst_n !== 1'b1 && edges < limit) begin
      applyStimulus(1'b0);
      edges++;
    end
  endtask

  // Directed scenarios followed by a randomized phase, all in one sequence.
  initial begin
    int n;
    n_checks   = 0;
    n_fails    = 0;
    NS[0] = 2;  HS[0] = 16;
    NS[1] = 3;  HS[1] = 1;
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    model_reset();

    $display("[TB] power-on reset");
    repeat (5) applyStimulus(1'b0);
    #3;
    rst = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      applyStimulus(1'b0);
      if (e == 4)  check1("por_b_edge4_rst_n", b_rst_n, 1'b0);
      if (e == 5)  check1("por_b_edge5_rst_n", b_rst_n, 1'b1);
      if (e == 18) check1("por_a_edge18_rst_n", a_rst_n, 1'b0);
      if (e == 19) begin
        check1("por_a_edge19_rst_n", a_rst_n, 1'b1);
        check1("por_a_edge19_done", a_done, 1'b1);
      end
      if (e == 20) begin
        check1("por_a_edge20_done", a_done, 1'b0);
        check1("por_a_edge20_busy", a_busy, 1'b0);
      end
    end

    $display("[TB] software reset");
    applyStimulus(1'b1);
    check1("sw_a_rst_n_low", a_rst_n, 1'b0);
    waitRise(40, n);
    checkInt("sw_release_edges", n, 16);
    check1("sw_done_pulse", a_done, 1'b1);
    applyStimulus(1'b0);
    check1("sw_done_clear", a_done, 1'b0);

    $display("[TB] re-triggered software reset");
    applyStimulus(1'b1);
    repeat (9) applyStimulus(1'b0);
    applyStimulus(1'b1);
    waitRise(40, n);
    checkInt("retrigger_release_edges", n + 10, 26);
    repeat (3) applyStimulus(1'b0);

    $display("[TB] async reset in RUN and mid-HOLD");
    asyncResetPulse(2);
    repeat (10) applyStimulus(1'b0);
    asyncResetPulse(0);
    waitRise(40, n);
    checkInt("async_rerelease_edges", n, 19);

    $display("[TB] request held through SYNC");
    asyncResetPulse(1);
    repeat (3) applyStimulus(1'b1);
    waitRise(40, n);
    checkInt("sync_req_ignored_edges", n + 3, 19);
    asyncResetPulse(1);
    repeat (4) applyStimulus(1'b1);
    waitRise(40, n);
    checkInt("sync_req_into_hold_edges", n + 4, 20);

    $display("[TB] randomized phase");
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 99) < 3) begin
        asyncResetPulse(int'($urandom_range(0, 2)));
      end else begin
        applyStimulus($urandom_range(0, 9) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
